serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Sequences a single 1-bit full-adder cell LSB-first for WIDTH cycles, keeping the running carry in a flop.
- Presents the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits between an operand source and a result consumer. Trades latency for area against a parallel adder.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; returns to IDLE and discards the in-flight operation.
- start_valid  input  1  operands present.
- start_ready  output  1  controller can accept operands.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- c_in  input  1  carry-in.
- done_valid  output  1  result available.
- done_ready  input  1  consumer accepts result.
- sum_out  output  WIDTH  registered sum.
- c_out  output  1  registered carry-out.
- busy  output  1  high in RUN.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (reset_n).
- While reset_n=0:
  - state=IDLE.
  - Shift registers, carry flop, bit counter, sum_out and c_out all 0.
  - done_valid=0, busy=0.
  - start_ready=1 once reset_n deasserts.
- States: IDLE, RUN, DONE.
- Handshake outputs decode from state: start_ready = (state==IDLE); busy = (state==RUN); done_valid = (state==DONE).
- IDLE:
  - On an edge with start_valid & start_ready: load a_sh<=a_in, b_sh<=b_in, carry<=c_in, cnt<=0, then go to RUN.
  - Operand inputs are don't-care after the accept edge.
- RUN, each edge:
  - Full-adder cell computes s,co from a_sh[0], b_sh[0], carry.
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right with zero fill; carry <= co; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: sum_out <= the final shifted sum, c_out <= co, go to DONE.
  - start_valid is ignored in RUN; start_ready stays 0.
- Latency: done_valid is first high in the cycle after the WIDTH-th RUN edge, i.e. WIDTH edges after the accept edge. WIDTH=1 gives 1 edge.
- DONE:
  - sum_out and c_out are held stable while done_valid & !done_ready.
  - On an edge with done_ready=1: go to IDLE.
  - sum_out and c_out keep their last value until the next completion. They are meaningful only while done_valid=1.
- No back-to-back overlap: a new operation is accepted no earlier than the cycle after the result handshake.
- clear:
  - In RUN or DONE: go to IDLE next edge, with no done_valid for the aborted operation.
  - In IDLE: clear has priority over start_valid; the operation is not accepted.
- Arithmetic: {c_out,sum_out} = a_in + b_in + c_in, computed modulo 2^(WIDTH+1). Overflow is reported only via c_out.
- reset_n asserted mid-RUN or mid-DONE: immediate return to the reset values above. The partial result is lost and no done_valid pulse is produced.

Decomposition:
- Shared package/include serial_adder_defs:
  - State encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- One sub-module, fa_cell:
  - Combinational 1-bit full adder, ports a, b, c_in, sum, c_out.
  - Instantiated once in the datapath.
- FSM, counter and shift registers live in serial_adder_ctrl itself.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, c_in=0, done_ready=1 -> done_valid exactly 8 edges after accept; sum_out=0x8D, c_out=0; start_ready=0 throughout RUN and DONE.
- a=0xFF, b=0x01, c_in=0 -> sum_out=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 -> sum_out=0xFF, c_out=1.
- Backpressure: a=0x10, b=0x20, done_ready held 0 for 5 cycles in DONE -> sum_out=0x30 stable and done_valid=1 for all 5 cycles; start_valid pulses during that window are not accepted; IDLE on the edge done_ready=1.
- Reset mid-RUN: pull reset_n low after 3 RUN edges -> all outputs return to reset values immediately. Next op a=0x07, b=0x09 -> sum_out=0x10, c_out=0.
- clear asserted on the 4th RUN edge -> IDLE next cycle, no done_valid. Following op a=0x80, b=0x80, c_in=0 -> sum_out=0x00, c_out=1.
- Exhaustive at WIDTH=2: all 32 combinations of a, b, c_in against the reference sum. Same at WIDTH=1: latency 1 edge, all 8 combinations match the full-adder truth table.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_adder_defs;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts operands, adds LSB-first through one full-adder
// cell over WIDTH cycles, then holds the registered result until the consumer takes it.
module serial_adder_ctrl
    import serial_adder_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum_out;
    logic [WIDTH-1:0] w_sum_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_c_out;
    logic             r_start_ready;
    logic             r_busy;
    logic             r_done_valid;
    logic             w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    fa_cell u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c_in  (r_carry),
        .sum   (w_s),
        .c_out (w_co)
    );

    // clear wins over both a new accept and a RUN step
    assign w_accept   = (r_state == ST_IDLE) && start_valid && !clear;
    assign w_step     = (r_state == ST_RUN) && !clear;
    assign w_last     = w_step && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sum_next = (r_sum_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_RUN;
            ST_RUN: begin
                if (clear)       w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
            end
            ST_DONE: if (clear || done_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake flags track the next state so they line up with r_state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_done_valid  <= 1'b0;
        end else begin
            r_start_ready <= (w_next == ST_IDLE);
            r_busy        <= (w_next == ST_RUN);
            r_done_valid  <= (w_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sum_out <= '0;
            r_c_out   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= c_in;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_next;
            r_carry  <= w_co;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum_out <= w_sum_next;
                r_c_out   <= w_co;
            end
        end
    end

    assign start_ready = r_start_ready;
    assign busy        = r_busy;
    assign done_valid  = r_done_valid;
    assign sum_out     = r_sum_out;
    assign c_out       = r_c_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8, 2 and 1.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=8 instance
    logic       sv8 = 0, sr8, dv8, dr8 = 1, clr8 = 0, ci8 = 0, co8, busy8;
    logic [7:0] a8 = 0, b8 = 0, s8;
    // WIDTH=2 instance
    logic       sv2 = 0, sr2, dv2, dr2 = 1, clr2 = 0, ci2 = 0, co2, busy2;
    logic [1:0] a2 = 0, b2 = 0, s2;
    // WIDTH=1 instance
    logic       sv1 = 0, sr1, dv1, dr1 = 1, clr1 = 0, ci1 = 0, co1, busy1;
    logic [0:0] a1 = 0, b1 = 0, s1;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .clear(clr8), .start_valid(sv8), .start_ready(sr8),
        .a_in(a8), .b_in(b8), .c_in(ci8), .done_valid(dv8), .done_ready(dr8),
        .sum_out(s8), .c_out(co8), .busy(busy8));
    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .clear(clr2), .start_valid(sv2), .start_ready(sr2),
        .a_in(a2), .b_in(b2), .c_in(ci2), .done_valid(dv2), .done_ready(dr2),
        .sum_out(s2), .c_out(co2), .busy(busy2));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clr1), .start_valid(sv1), .start_ready(sr1),
        .a_in(a1), .b_in(b1), .c_in(ci1), .done_valid(dv1), .done_ready(dr1),
        .sum_out(s1), .c_out(co1), .busy(busy1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] sum;
        logic       co;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: the whole operation is just (WIDTH+1)-bit addition
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        return 9'(a) + 9'(b) + 9'(ci);
    endfunction

    // Issue one op on dut8 and return at the first negedge where done_valid is seen
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       output logic [7:0] sum, output logic co, output int lat, output int sr_bad);
        sr_bad = 0;
        chk("sr8_before_accept", 32'(sr8), 32'd1);
        a8 = a; b8 = b; ci8 = ci; sv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv8 = 1'b0; a8 = ~a; b8 = ~b; ci8 = ~ci;
        lat = 0;
        while (!dv8 && lat < 64) begin
            if (sr8) sr_bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (sr8) sr_bad++;
        if (!dv8) chk("dv8_timeout", 32'd0, 32'd1);
        sum = s8;
        co  = co8;
    endtask

    task automatic ack8();
        @(posedge clk);
        @(negedge clk);
        chk("dv8_after_ack", 32'(dv8), 32'd0);
        chk("sr8_after_ack", 32'(sr8), 32'd1);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic ci);
        int lat;
        a2 = a; b2 = b; ci2 = ci; sv2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv2 = 1'b0;
        lat = 0;
        while (!dv2 && lat < 16) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w2_latency", 32'(lat), 32'd2);
        chk($sformatf("w2_sum a=%0d b=%0d ci=%0d", a, b, ci), 32'({co2, s2}),
            32'(3'(a) + 3'(b) + 3'(ci)));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op1(input logic a, input logic b, input logic ci);
        int lat;
        a1 = a; b1 = b; ci1 = ci; sv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv1 = 1'b0;
        lat = 0;
        while (!dv1 && lat < 16) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("w1_latency", 32'(lat), 32'd1);
        chk($sformatf("w1_fa a=%0d b=%0d ci=%0d", a, b, ci), 32'({co1, s1}),
            32'(2'(a) + 2'(b) + 2'(ci)));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] sum;
        logic       co;
        logic [8:0] exp9;
        int         lat;
        int         sr_bad;
        int         dv_seen;

        vecs[0] = '{a: 8'h5A, b: 8'h33, ci: 1'b0, sum: 8'h8D, co: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, sum: 8'h00, co: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, sum: 8'hFF, co: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, ci: 1'b1, sum: 8'h01, co: 1'b0};
        vecs[4] = '{a: 8'h7F, b: 8'h80, ci: 1'b1, sum: 8'h00, co: 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_dv8", 32'(dv8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_sum8", 32'(s8), 32'd0);
        chk("rst_co8", 32'(co8), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_sr8", 32'(sr8), 32'd1);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].ci, sum, co, lat, sr_bad);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].co));
            chk($sformatf("vec%0d_sr_low", i), 32'(sr_bad), 32'd0);
            ack8();
        end

        // Backpressure: hold result for 5 cycles while start_valid is pulsed
        dr8 = 1'b0;
        op8(8'h10, 8'h20, 1'b0, sum, co, lat, sr_bad);
        for (int i = 0; i < 5; i++) begin
            chk("bp_dv8", 32'(dv8), 32'd1);
            chk("bp_sum8", 32'(s8), 32'h30);
            chk("bp_sr8", 32'(sr8), 32'd0);
            sv8 = i[0]; a8 = 8'hAA; b8 = 8'h11;
            @(posedge clk);
            @(negedge clk);
        end
        sv8 = 1'b0;
        dr8 = 1'b1;
        ack8();
        chk("bp_busy8_after", 32'(busy8), 32'd0);

        // Reset mid-RUN after 3 RUN edges
        a8 = 8'h55; b8 = 8'h66; ci8 = 1'b0; sv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrun_busy_before", 32'(busy8), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrun_rst_busy8", 32'(busy8), 32'd0);
        chk("midrun_rst_dv8", 32'(dv8), 32'd0);
        chk("midrun_rst_sum8", 32'(s8), 32'd0);
        chk("midrun_rst_co8", 32'(co8), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        op8(8'h07, 8'h09, 1'b0, sum, co, lat, sr_bad);
        chk("post_rst_sum", 32'(sum), 32'h10);
        chk("post_rst_co", 32'(co), 32'd0);
        ack8();

        // clear sampled on the 4th RUN edge
        a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0; sv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr8 = 1'b0;
        chk("clr_busy8", 32'(busy8), 32'd0);
        chk("clr_sr8", 32'(sr8), 32'd1);
        dv_seen = 0;
        repeat (10) begin
            if (dv8) dv_seen++;
            @(negedge clk);
        end
        chk("clr_no_done", 32'(dv_seen), 32'd0);

        // clear beats start_valid in IDLE
        clr8 = 1'b1; sv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr8 = 1'b0; sv8 = 1'b0;
        chk("clr_idle_busy8", 32'(busy8), 32'd0);
        chk("clr_idle_sr8", 32'(sr8), 32'd1);

        op8(8'h80, 8'h80, 1'b0, sum, co, lat, sr_bad);
        chk("post_clr_sum", 32'(sum), 32'h00);
        chk("post_clr_co", 32'(co), 32'd1);
        ack8();

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = ref8(ra, rb, rc);
            op8(ra, rb, rc, sum, co, lat, sr_bad);
            chk($sformatf("rnd%0d_result a=%0h b=%0h ci=%0d", i, ra, rb, rc), 32'({co, sum}), 32'(exp9));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd8);
            ack8();
        end

        // Exhaustive narrow widths
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    op2(2'(a), 2'(b), 1'(c));
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++)
                    op1(1'(a), 1'(b), 1'(c));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
